mag_comparator: RTL and testbench

- Registered magnitude comparator for two WIDTH-bit operands A and B.
- Produces exactly one of three result flags: equal, greater-than or less-than.
- Sits in datapath control logic wherever a one-cycle-latency compare result with a valid strobe is needed.
- Supports unsigned or two's-complement compare, selectable per transaction.

---
 rtl/mag_comparator.sv | 104 ++++++++++
 tb/tb_mag_comparator.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mag_comparator.sv
// rtl/mag_comparator.sv - registered signed/unsigned magnitude comparator, 1-cycle latency
// Optional result counters enabled by defining COMPARATOR_STATS_EN.
module mag_comparator #(
    parameter int WIDTH = 4
`ifdef COMPARATOR_STATS_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             cmp_signed,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             AEqualB,
    output logic             AgreaterThanB,
    output logic             ALessThanB,
    output logic             out_valid
`ifdef COMPARATOR_STATS_EN
    ,
    input  logic             clear_stats,
    output logic [CNT_W-1:0] eq_count,
    output logic [CNT_W-1:0] gt_count,
    output logic [CNT_W-1:0] lt_count
`endif
);

    logic [WIDTH-1:0] sign_mask;
    logic [WIDTH-1:0] a_x;
    logic [WIDTH-1:0] b_x;
    logic             eq_d, gt_d, lt_d;
    logic             eq_q, gt_q, lt_q, valid_q;

    // Flipping the sign bit maps two's-complement order onto unsigned order.
    always_comb begin
        sign_mask            = '0;
        sign_mask[WIDTH-1]   = cmp_signed;
        a_x                  = A ^ sign_mask;
        b_x                  = B ^ sign_mask;
        eq_d                 = (A == B);
        gt_d                 = (a_x > b_x);
        lt_d                 = !eq_d && !gt_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            eq_q    <= 1'b0;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= in_valid;
            if (in_valid) begin
                eq_q <= eq_d;
                gt_q <= gt_d;
                lt_q <= lt_d;
            end
        end
    end

    assign AEqualB       = eq_q;
    assign AgreaterThanB = gt_q;
    assign ALessThanB    = lt_q;
    assign out_valid     = valid_q;

`ifdef COMPARATOR_STATS_EN
    logic [CNT_W-1:0] eq_cnt_q, gt_cnt_q, lt_cnt_q;
    logic [CNT_W-1:0] eq_cnt_d, gt_cnt_d, lt_cnt_d;

    // Clear takes priority over counting the compare accepted on the same edge.
    always_comb begin
        eq_cnt_d = eq_cnt_q;
        gt_cnt_d = gt_cnt_q;
        lt_cnt_d = lt_cnt_q;
        if (clear_stats) begin
            eq_cnt_d = '0;
            gt_cnt_d = '0;
            lt_cnt_d = '0;
        end else if (in_valid) begin
            if (eq_d && (eq_cnt_q != '1)) eq_cnt_d = eq_cnt_q + 1'b1;
            if (gt_d && (gt_cnt_q != '1)) gt_cnt_d = gt_cnt_q + 1'b1;
            if (lt_d && (lt_cnt_q != '1)) lt_cnt_d = lt_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            eq_cnt_q <= '0;
            gt_cnt_q <= '0;
            lt_cnt_q <= '0;
        end else begin
            eq_cnt_q <= eq_cnt_d;
            gt_cnt_q <= gt_cnt_d;
            lt_cnt_q <= lt_cnt_d;
        end
    end

    assign eq_count = eq_cnt_q;
    assign gt_count = gt_cnt_q;
    assign lt_count = lt_cnt_q;
`endif

endmodule

// File: tb/tb_mag_comparator.sv
// tb/tb_mag_comparator.sv - scoreboard bench for mag_comparator (define COMPARATOR_STATS_EN for counters)
module tb_mag_comparator;

    localparam int W  = 4;
    localparam int CW = 2;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         cmp_signed;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         AEqualB, AgreaterThanB, ALessThanB, out_valid;
`ifdef COMPARATOR_STATS_EN
    logic          clear_stats;
    logic [CW-1:0] eq_count, gt_count, lt_count;
`endif

    int pass_cnt = 0;
    int total    = 0;
    logic [2:0] sb[$];
    logic [2:0] last_exp;
    int m_eq, m_gt, m_lt;

`ifdef COMPARATOR_STATS_EN
    mag_comparator #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .cmp_signed(cmp_signed),
        .A(A), .B(B), .AEqualB(AEqualB), .AgreaterThanB(AgreaterThanB),
        .ALessThanB(ALessThanB), .out_valid(out_valid),
        .clear_stats(clear_stats), .eq_count(eq_count), .gt_count(gt_count),
        .lt_count(lt_count));
`else
    mag_comparator #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .cmp_signed(cmp_signed),
        .A(A), .B(B), .AEqualB(AEqualB), .AgreaterThanB(AgreaterThanB),
        .ALessThanB(ALessThanB), .out_valid(out_valid));
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, passed=%0d total=%0d", pass_cnt, total);
        $fatal(1);
    end

    function automatic logic [2:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        int ai, bi;
        ai = int'(a);
        bi = int'(b);
        if (s && a[W-1]) ai = ai - (1 << W);
        if (s && b[W-1]) bi = bi - (1 << W);
        if (ai == bi) return 3'b100;
        if (ai > bi)  return 3'b010;
        return 3'b001;
    endfunction

    // Drives one accepted compare, pushes its expectation, returns #1 after the edge.
    task automatic drive_cmp(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input logic clr);
        logic [2:0] e;
        A = a; B = b; cmp_signed = s; in_valid = 1'b1;
        e = model(a, b, s);
        sb.push_back(e);
`ifdef COMPARATOR_STATS_EN
        clear_stats = clr;
        if (clr) begin
            m_eq = 0; m_gt = 0; m_lt = 0;
        end else begin
            if (e[2] && m_eq < (1 << CW) - 1) m_eq++;
            if (e[1] && m_gt < (1 << CW) - 1) m_gt++;
            if (e[0] && m_lt < (1 << CW) - 1) m_lt++;
        end
`else
        if (clr) m_eq = 0;
`endif
        @(posedge clk); #1;
        in_valid = 1'b0;
`ifdef COMPARATOR_STATS_EN
        clear_stats = 1'b0;
`endif
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; cmp_signed = 1'b0; A = '0; B = '0;
`ifdef COMPARATOR_STATS_EN
        clear_stats = 1'b0;
`endif
        m_eq = 0; m_gt = 0; m_lt = 0;
        #20;
        total++;
        if ({AEqualB, AgreaterThanB, ALessThanB, out_valid} !== 4'b0000)
            $display("FAIL reset_flags: got %b want 0000", {AEqualB, AgreaterThanB, ALessThanB, out_valid});
        else pass_cnt++;
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            total++;
            if ({AEqualB, AgreaterThanB, ALessThanB, out_valid} !== 4'b0000)
                $display("FAIL idle_after_reset: got %b want 0000", {AEqualB, AgreaterThanB, ALessThanB, out_valid});
            else pass_cnt++;
        end
`ifdef COMPARATOR_STATS_EN
        total++;
        if ({eq_count, gt_count, lt_count} !== '0)
            $display("FAIL reset_counters: got %h want 0", {eq_count, gt_count, lt_count});
        else pass_cnt++;
`endif
    endtask

    task automatic test_unsigned_basic();
        logic [W-1:0] av[3] = '{4'd5, 4'd9, 4'd2};
        logic [W-1:0] bv[3] = '{4'd5, 4'd3, 4'd14};
        for (int i = 0; i < 3; i++) begin
            drive_cmp(av[i], bv[i], 1'b0, 1'b0);
            last_exp = sb.pop_front();
            total++;
            if ({AEqualB, AgreaterThanB, ALessThanB, out_valid} !== {last_exp, 1'b1})
                $display("FAIL unsigned_basic[%0d]: got %b want %b", i,
                         {AEqualB, AgreaterThanB, ALessThanB, out_valid}, {last_exp, 1'b1});
            else pass_cnt++;
        end
    endtask

    task automatic test_signed_vs_unsigned();
        logic [W-1:0] av[4] = '{4'b1000, 4'b1000, 4'hF, 4'hF};
        logic [W-1:0] bv[4] = '{4'b0111, 4'b0111, 4'h0, 4'h0};
        logic         sv[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            drive_cmp(av[i], bv[i], sv[i], 1'b0);
            last_exp = sb.pop_front();
            total++;
            if ({AEqualB, AgreaterThanB, ALessThanB, out_valid} !== {last_exp, 1'b1})
                $display("FAIL signed_mode[%0d]: got %b want %b", i,
                         {AEqualB, AgreaterThanB, ALessThanB, out_valid}, {last_exp, 1'b1});
            else pass_cnt++;
        end
        drive_cmp(4'd0, 4'd0, 1'b1, 1'b0);
        last_exp = sb.pop_front();
        total++;
        if ({AEqualB, AgreaterThanB, ALessThanB} !== 3'b100)
            $display("FAIL zero_equal: got %b want 100", {AEqualB, AgreaterThanB, ALessThanB});
        else pass_cnt++;
    endtask

    task automatic test_hold_gating();
        drive_cmp(4'd9, 4'd3, 1'b0, 1'b0);
        last_exp = sb.pop_front();
        A = 4'd1; B = 4'd1; in_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            total++;
            if ({AEqualB, AgreaterThanB, ALessThanB, out_valid} !== {last_exp, 1'b0})
                $display("FAIL hold[%0d]: got %b want %b", i,
                         {AEqualB, AgreaterThanB, ALessThanB, out_valid}, {last_exp, 1'b0});
            else pass_cnt++;
        end
    endtask

    task automatic test_back_to_back_random();
        for (int i = 0; i < 24; i++) begin
            drive_cmp(W'($urandom_range(0, (1 << W) - 1)), W'($urandom_range(0, (1 << W) - 1)),
                      1'($urandom_range(0, 1)), 1'b0);
            if (sb.size() == 0) begin
                total++;
                $display("FAIL soak_queue[%0d]: got empty scoreboard want one entry", i);
            end else begin
                last_exp = sb.pop_front();
                total++;
                if ({AEqualB, AgreaterThanB, ALessThanB, out_valid} !== {last_exp, 1'b1} ||
                    $countones({AEqualB, AgreaterThanB, ALessThanB}) != 1)
                    $display("FAIL soak[%0d]: got %b want %b", i,
                             {AEqualB, AgreaterThanB, ALessThanB, out_valid}, {last_exp, 1'b1});
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_reset_midstream();
        drive_cmp(4'd2, 4'd14, 1'b0, 1'b0);
        last_exp = sb.pop_front();
        A = 4'd5; B = 4'd5; in_valid = 1'b1;
        #2 rst = 1'b1;
        #1;
        total++;
        if ({AEqualB, AgreaterThanB, ALessThanB, out_valid} !== 4'b0000)
            $display("FAIL midstream_reset: got %b want 0000", {AEqualB, AgreaterThanB, ALessThanB, out_valid});
        else pass_cnt++;
        m_eq = 0; m_gt = 0; m_lt = 0;
        in_valid = 1'b0;
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        total++;
        if ({AEqualB, AgreaterThanB, ALessThanB, out_valid} !== 4'b0000)
            $display("FAIL after_midstream_reset: got %b want 0000", {AEqualB, AgreaterThanB, ALessThanB, out_valid});
        else pass_cnt++;
    endtask

`ifdef COMPARATOR_STATS_EN
    task automatic test_stats();
        for (int i = 0; i < 5; i++) begin
            drive_cmp(4'd6, 4'd6, 1'b0, 1'b0);
            last_exp = sb.pop_front();
            total++;
            if (int'(eq_count) != m_eq)
                $display("FAIL eq_count_sat[%0d]: got %0d want %0d", i, eq_count, m_eq);
            else pass_cnt++;
        end
        total++;
        if (eq_count !== 2'd3)
            $display("FAIL eq_count_final: got %0d want 3", eq_count);
        else pass_cnt++;
        drive_cmp(4'd9, 4'd3, 1'b0, 1'b1);
        last_exp = sb.pop_front();
        total++;
        if ({eq_count, gt_count, lt_count} !== '0 || {AEqualB, AgreaterThanB, ALessThanB} !== 3'b010)
            $display("FAIL clear_wins: got cnt=%h flags=%b want cnt=0 flags=010",
                     {eq_count, gt_count, lt_count}, {AEqualB, AgreaterThanB, ALessThanB});
        else pass_cnt++;
        drive_cmp(4'd9, 4'd3, 1'b0, 1'b0);
        last_exp = sb.pop_front();
        total++;
        if (gt_count !== 2'd1 || eq_count !== 2'd0 || lt_count !== 2'd0)
            $display("FAIL count_after_clear: got eq=%0d gt=%0d lt=%0d want 0/1/0", eq_count, gt_count, lt_count);
        else pass_cnt++;
    endtask
`endif

    initial begin
        test_reset();
        test_unsigned_basic();
        test_signed_vs_unsigned();
        test_hold_gating();
        test_back_to_back_random();
        test_reset_midstream();
`ifdef COMPARATOR_STATS_EN
        test_stats();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
